draw_priority_arbiter: RTL and testbench

Per-pixel controller that shares the single 8-bit VGA colour output between the board background and up to `NUM_OBJ` foreground drawers (balls, cue, pockets) using fixed priority. It also tracks frame boundaries and accumulates which objects overlapped on screen during each frame, reporting a collision mask once per frame to game logic. It sits between all `drawingRequest*`/`RGBout*` producers and the VGA output stage.

---
 rtl/draw_pkg.sv | 18 +
 rtl/frame_tracker.sv | 66 ++++++
 rtl/draw_priority_arbiter.sv | 98 +++++++++
 tb/tb_draw_priority_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and screen constants for the pixel draw path.
package draw_pkg;

  typedef logic [7:0]         rgb_t;
  typedef logic signed [10:0] coord_t;

  localparam rgb_t TRANSPARENT_COLOR = 8'hFF;
  localparam int   SCREEN_W          = 640;
  localparam int   SCREEN_H          = 480;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    REPORT,
    WAIT
  } frame_state_t;

endpackage

// File: rtl/frame_tracker.sv
// Delays pixel coordinates to line up with source-registered draw requests,
// detects frame start/end edges and sequences the per-frame collision report.
module frame_tracker
  import draw_pkg::*;
#(
  parameter int ACTIVE_W = SCREEN_W,
  parameter int ACTIVE_H = SCREEN_H
) (
  input  logic         clk,
  input  logic         resetN,
  input  coord_t       pixelX,
  input  coord_t       pixelY,
  output coord_t       pxD,
  output coord_t       pyD,
  output logic         startOfFrame,
  output logic         frameStart,
  output logic         inActive,
  output logic         report,
  output frame_state_t state
);

  localparam coord_t LAST_H = coord_t'(ACTIVE_H);

  frame_state_t next_state;
  logic         was_origin;
  logic         was_below;
  logic         at_origin;
  logic         frame_end;

  // Edges only: a held (0,0) or a held last row fires once.
  assign at_origin  = (pxD == '0) && (pyD == '0);
  assign frameStart = at_origin && !was_origin;
  assign frame_end  = (pyD == LAST_H) && was_below;
  assign inActive   = (state == ACTIVE);
  assign report     = (state == ACTIVE) && frame_end;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      pxD          <= '1;
      pyD          <= '1;
      was_origin   <= 1'b0;
      was_below    <= 1'b1;
      startOfFrame <= 1'b0;
      state        <= IDLE;
    end else begin
      pxD          <= pixelX;
      pyD          <= pixelY;
      was_origin   <= at_origin;
      was_below    <= (pyD < LAST_H);
      startOfFrame <= frameStart;
      state        <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (frameStart) next_state = ACTIVE;
      ACTIVE:  if (frame_end) next_state = REPORT;
      REPORT:  next_state = WAIT;
      WAIT:    if (frameStart) next_state = ACTIVE;
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/draw_priority_arbiter.sv
// Fixed-priority colour mux over foreground objects and the board, plus a
// per-frame accumulator of which objects overlapped on the visible screen.
module draw_priority_arbiter
  import draw_pkg::*;
#(
  parameter int   NUM_OBJ     = 4,
  parameter rgb_t BG_COLOR    = 8'h00,
  parameter rgb_t TRANSPARENT = TRANSPARENT_COLOR,
  parameter int   ACTIVE_W    = SCREEN_W,
  parameter int   ACTIVE_H    = SCREEN_H
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic signed [10:0]       pixelX,
  input  logic signed [10:0]       pixelY,
  input  logic [NUM_OBJ-1:0]       drawingRequest,
  input  logic [NUM_OBJ-1:0][7:0]  RGBin,
  input  logic                     drawingRequestBoard,
  input  logic [7:0]               RGBoutBoard,
  output logic [7:0]               RGBout,
  output logic                     startOfFrame,
  output logic                     collisionValid,
  output logic [NUM_OBJ-1:0]       collisionMask,
  output frame_state_t             frameState
);

  localparam coord_t             LAST_W = coord_t'(ACTIVE_W);
  localparam coord_t             LAST_H = coord_t'(ACTIVE_H);
  localparam logic [NUM_OBJ-1:0] ONE    = NUM_OBJ'(1);

  coord_t             pxD;
  coord_t             pyD;
  logic               frame_start;
  logic               in_active;
  logic               report;
  logic [NUM_OBJ-1:0] obj_valid;
  logic [NUM_OBJ-1:0] acc;
  logic [NUM_OBJ-1:0] acc_base;
  logic [NUM_OBJ-1:0] overlap_bits;
  logic               on_screen;
  logic               multi;
  rgb_t               sel_color;

  frame_tracker #(
    .ACTIVE_W(ACTIVE_W),
    .ACTIVE_H(ACTIVE_H)
  ) u_frame_tracker (
    .clk         (clk),
    .resetN      (resetN),
    .pixelX      (pixelX),
    .pixelY      (pixelY),
    .pxD         (pxD),
    .pyD         (pyD),
    .startOfFrame(startOfFrame),
    .frameStart  (frame_start),
    .inActive    (in_active),
    .report      (report),
    .state       (frameState)
  );

  always_comb begin
    obj_valid = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      obj_valid[i] = drawingRequest[i] && (RGBin[i] != TRANSPARENT);
    end
  end

  // Walk from lowest priority upward so the lowest valid index wins.
  always_comb begin
    sel_color = drawingRequestBoard ? RGBoutBoard : BG_COLOR;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (obj_valid[i]) sel_color = RGBin[i];
    end
  end

  assign on_screen = !pxD[10] && (pxD < LAST_W) && !pyD[10] && (pyD < LAST_H);
  // Two or more set bits: clearing the lowest set bit leaves something.
  assign multi     = |(obj_valid & (obj_valid - ONE));

  // The frame-start cycle itself belongs to the new frame, so it may count.
  assign overlap_bits = (on_screen && multi && (in_active || frame_start)) ? obj_valid : '0;
  assign acc_base     = (frame_start || report) ? '0 : acc;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      RGBout         <= BG_COLOR;
      acc            <= '0;
      collisionValid <= 1'b0;
      collisionMask  <= '0;
    end else begin
      RGBout         <= sel_color;
      acc            <= acc_base | overlap_bits;
      collisionValid <= report;
      if (report) collisionMask <= acc | overlap_bits;
    end
  end

endmodule

// File: tb/tb_draw_priority_arbiter.sv
// Bench for draw_priority_arbiter on a reduced 64x48 screen: colour vectors,
// then pixel-swept frames checked against a frame-level overlap model.
module tb_draw_priority_arbiter;
  import draw_pkg::*;

  localparam int   AW = 64;
  localparam int   AH = 48;
  localparam rgb_t BG = 8'h00;
  localparam rgb_t TR = 8'hFF;

  logic               clk = 1'b0;
  logic               resetN;
  logic signed [10:0] pixelX;
  logic signed [10:0] pixelY;
  logic [3:0]         drawingRequest;
  logic [3:0][7:0]    RGBin;
  logic               drawingRequestBoard;
  rgb_t               RGBoutBoard;
  rgb_t               RGBout;
  logic               startOfFrame;
  logic               collisionValid;
  logic [3:0]         collisionMask;
  frame_state_t       frameState;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         f_sof = 0;
  int         f_cv = 0;
  int         sof_cyc = -1;
  int         cv_cyc = -1;
  logic [3:0] cv_mask = '0;
  logic [3:0] exp_acc = '0;
  logic [3:0] rnd_en = '0;

  typedef struct {
    string           name;
    logic [3:0]      req;
    logic [3:0][7:0] rgb;
    logic            brq;
    rgb_t            brgb;
    rgb_t            exp;
  } vec_t;
  vec_t tbl[10];

  draw_priority_arbiter #(
    .NUM_OBJ    (4),
    .BG_COLOR   (BG),
    .TRANSPARENT(TR),
    .ACTIVE_W   (AW),
    .ACTIVE_H   (AH)
  ) dut (
    .clk                (clk),
    .resetN             (resetN),
    .pixelX             (pixelX),
    .pixelY             (pixelY),
    .drawingRequest     (drawingRequest),
    .RGBin              (RGBin),
    .drawingRequestBoard(drawingRequestBoard),
    .RGBoutBoard        (RGBoutBoard),
    .RGBout             (RGBout),
    .startOfFrame       (startOfFrame),
    .collisionValid     (collisionValid),
    .collisionMask      (collisionMask),
    .frameState         (frameState)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] vmask(input logic [3:0] r, input logic [3:0][7:0] c);
    logic [3:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i] = r[i] && (c[i] != TR);
    return v;
  endfunction

  function automatic rgb_t ref_rgb(input logic [3:0] r, input logic [3:0][7:0] c,
                                   input logic b, input rgb_t bc);
    rgb_t res;
    res = b ? bc : BG;
    for (int i = 3; i >= 0; i--) if (r[i] && (c[i] != TR)) res = c[i];
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: predict RGBout from the inputs now applied, then sample at edge+1.
  task automatic step();
    rgb_t e;
    e = resetN ? ref_rgb(drawingRequest, RGBin, drawingRequestBoard, RGBoutBoard) : BG;
    @(posedge clk);
    #1;
    cyc++;
    if (startOfFrame) begin
      f_sof++;
      sof_cyc = cyc;
    end
    if (collisionValid) begin
      f_cv++;
      cv_cyc  = cyc;
      cv_mask = collisionMask;
    end
    chk("rgbout", 32'(RGBout), 32'(e));
  endtask

  task automatic add_vec(input int i, input string name, input logic [3:0] req,
                         input logic [3:0][7:0] rgb, input logic brq, input rgb_t brgb,
                         input rgb_t exp);
    tbl[i].name = name;
    tbl[i].req  = req;
    tbl[i].rgb  = rgb;
    tbl[i].brq  = brq;
    tbl[i].brgb = brgb;
    tbl[i].exp  = exp;
  endtask

  // Scene content for pixel (x,y); returned requests apply one cycle later.
  task automatic gen(input int mode, input int x, input int y, output logic [3:0] r,
                     output logic [3:0][7:0] c, output logic b, output rgb_t bc);
    r  = '0;
    c  = '0;
    b  = (x >= 0) && (x < AW) && (y >= 0) && (y < AH);
    bc = 8'(x + 3 * y);
    case (mode)
      0: begin
        if (x == 10 && y == 5) begin r = 4'b0101; c[0] = 8'h1C; c[2] = 8'hE0; end
        if (x == 12 && y == 5) begin r = 4'b0101; c[0] = TR;    c[2] = 8'hE0; end
        if (x == 30 && y == 7) begin r = 4'b1010; c[1] = TR;    c[3] = 8'h03; end
      end
      1: begin
        if ((x == -5 || x == AW + 5) && y == 10) begin
          r = 4'b1010; c[1] = 8'h55; c[3] = 8'hAA;
        end
        if (x == 5 && y == 10) begin r = 4'b0010; c[1] = 8'h55; end
      end
      3: if (x == 20 && y == 10) begin r = 4'b1010; c[1] = 8'h1C; c[3] = 8'hE0; end
      default: begin
        for (int i = 0; i < 4; i++) begin
          r[i] = rnd_en[i] && ($urandom_range(0, 11) == 0);
          c[i] = ($urandom_range(0, 3) == 0) ? TR : 8'($urandom_range(0, 254));
        end
        b  = ($urandom_range(0, 1) == 1);
        bc = 8'($urandom);
      end
    endcase
  endtask

  task automatic run_frame(input int mode, input int abort_y, input int rst_x, input int rst_y,
                           input bit exp_report, input string tag);
    logic [3:0]      pr, nr;
    logic [3:0][7:0] pc, nc;
    logic            pb, nb;
    rgb_t            pbc, nbc;
    int              p_origin;
    int              p_end;
    p_origin = -1;
    p_end    = -1;
    pr = '0; pc = '0; pb = 1'b0; pbc = '0;
    f_sof = 0; f_cv = 0; exp_acc = '0;
    for (int y = 0; y <= AH + 3; y++) begin
      if (y == abort_y) break;
      for (int x = -8; x < AW + 8; x++) begin
        pixelX = 11'(x);
        pixelY = 11'(y);
        drawingRequest      = pr;
        RGBin               = pc;
        drawingRequestBoard = pb;
        RGBoutBoard         = pbc;
        if (x == 0 && y == 0) p_origin = cyc + 1;
        if (x == -8 && y == AH) p_end = cyc + 1;
        gen(mode, x, y, nr, nc, nb, nbc);
        if (x >= 0 && x < AW && y >= 0 && y < AH && $countones(vmask(nr, nc)) >= 2)
          exp_acc |= vmask(nr, nc);
        pr = nr; pc = nc; pb = nb; pbc = nbc;
        resetN = !(x == rst_x && y == rst_y);
        step();
        if (!resetN) begin
          chk({tag, "_rst_sof"}, 32'(startOfFrame), 32'(0));
          chk({tag, "_rst_valid"}, 32'(collisionValid), 32'(0));
          chk({tag, "_rst_mask"}, 32'(collisionMask), 32'(0));
          chk({tag, "_rst_state"}, 32'(frameState), 32'(IDLE));
          resetN = 1'b1;
        end
      end
    end
    chk({tag, "_sof_count"}, 32'(f_sof), 32'(1));
    chk({tag, "_sof_cycle"}, 32'(sof_cyc), 32'(p_origin + 1));
    if (exp_report) begin
      chk({tag, "_report_count"}, 32'(f_cv), 32'(1));
      chk({tag, "_report_cycle"}, 32'(cv_cyc), 32'(p_end + 1));
      chk({tag, "_report_mask"}, 32'(cv_mask), 32'(exp_acc));
    end else begin
      chk({tag, "_no_report"}, 32'(f_cv), 32'(0));
    end
  endtask

  initial begin
    resetN              = 1'b0;
    pixelX              = 11'(AW + 2);
    pixelY              = 11'(AH + 2);
    drawingRequest      = '0;
    RGBin               = '0;
    drawingRequestBoard = 1'b0;
    RGBoutBoard         = '0;
    step();
    step();
    chk("reset_sof", 32'(startOfFrame), 32'(0));
    chk("reset_valid", 32'(collisionValid), 32'(0));
    chk("reset_mask", 32'(collisionMask), 32'(0));
    chk("reset_state", 32'(frameState), 32'(IDLE));
    resetN = 1'b1;

    add_vec(0, "prio_obj1",      4'b0110, {8'h00, 8'hE0, 8'h1C, 8'h00}, 1'b1, 8'h14, 8'h1C);
    add_vec(1, "drop_obj1",      4'b0100, {8'h00, 8'hE0, 8'h1C, 8'h00}, 1'b1, 8'h14, 8'hE0);
    add_vec(2, "board_only",     4'b0000, {8'h00, 8'hE0, 8'h1C, 8'h00}, 1'b1, 8'h14, 8'h14);
    add_vec(3, "background",     4'b0000, {8'h00, 8'hE0, 8'h1C, 8'h00}, 1'b0, 8'h14, 8'h00);
    add_vec(4, "transparent0",   4'b0001, {8'h00, 8'h00, 8'h00, 8'hFF}, 1'b1, 8'h14, 8'h14);
    add_vec(5, "obj3_only",      4'b1000, {8'h33, 8'h00, 8'h00, 8'h00}, 1'b1, 8'h14, 8'h33);
    add_vec(6, "obj0_wins",      4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b1, 8'h14, 8'h11);
    add_vec(7, "skip_transp",    4'b1001, {8'h44, 8'h00, 8'h00, 8'hFF}, 1'b0, 8'h14, 8'h44);
    add_vec(8, "all_transp",     4'b1111, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b0, 8'h14, 8'h00);
    add_vec(9, "board_ff_drawn", 4'b0000, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 8'hFF, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      drawingRequest      = tbl[i].req;
      RGBin               = tbl[i].rgb;
      drawingRequestBoard = tbl[i].brq;
      RGBoutBoard         = tbl[i].brgb;
      step();
      chk(tbl[i].name, 32'(RGBout), 32'(tbl[i].exp));
    end

    // Holding (0,0) for several cycles must produce exactly one start pulse.
    drawingRequest      = '0;
    drawingRequestBoard = 1'b0;
    f_sof               = 0;
    pixelX              = '0;
    pixelY              = '0;
    for (int i = 0; i < 4; i++) step();
    pixelX = 11'(AW + 2);
    pixelY = 11'(AH + 2);
    step();
    step();
    chk("held_origin_sof", 32'(f_sof), 32'(1));
    chk("held_origin_state", 32'(frameState), 32'(ACTIVE));

    run_frame(0, -1, -99, -99, 1'b1, "sweep");
    chk("sweep_mask_value", 32'(cv_mask), 32'(4'b0101));
    run_frame(1, -1, -99, -99, 1'b1, "offscreen");
    chk("offscreen_mask_value", 32'(cv_mask), 32'(4'b0000));
    run_frame(3, 20, -99, -99, 1'b0, "aborted");
    run_frame(0, -1, -99, -99, 1'b1, "after_abort");
    chk("after_abort_mask_value", 32'(cv_mask), 32'(4'b0101));
    run_frame(3, -1, AW / 2, AH / 2, 1'b0, "reset_mid");
    run_frame(0, -1, -99, -99, 1'b1, "after_reset");
    for (int k = 0; k < 3; k++) begin
      rnd_en = 4'($urandom_range(1, 15));
      run_frame(2, -1, -99, -99, 1'b1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
